// File: rtl/id_regfile_sb.sv
// id_regfile_sb -- decode-stage register file with a per-register pending
// scoreboard.
//
// Each architectural register has a small down-counter that is loaded when
// decode issues an instruction writing that register. While the counter is
// nonzero the register is "pending", and a decode read of it raises stall.
// A writeback clears the counter. If the counter runs out with no writeback,
// the sticky err_lost flag is set.
//
// Ports
//   clk, rst_n  rising-edge clock, asynchronous active-low reset
//   rd_en       [NRD]         per-port read enable (source used by decode)
//   rd_addr     [NRD*ADDR_W]  read addresses, port i at [i*ADDR_W +: ADDR_W]
//   rd_data     [NRD*DATA_W]  combinational read data, same packing
//   wr_en/wr_addr/wr_data     writeback port (write-through to readers)
//   iss_valid/iss_dst/iss_lat issue of a result-producing instruction
//   stall       hold decode and fetch
//   pc_write    ~stall
//   pend_cnt    registered number of pending registers
//   err_lost    sticky: a pending counter expired without writeback
//
// Issue handshake: an issue is taken in a cycle when iss_valid is high and
// stall is low. stall acts as the ready signal. iss_valid seen while stall is
// high is dropped, not held. Decode must re-present the instruction.
// Issues to register 0 are ignored because r0 is hardwired to zero.

module id_regfile_sb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NRD    = 2,
  parameter int LAT_W  = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NRD-1:0]        rd_en,
  input  logic [NRD*ADDR_W-1:0] rd_addr,
  output logic [NRD*DATA_W-1:0] rd_data,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic                  iss_valid,
  input  logic [ADDR_W-1:0]     iss_dst,
  input  logic [LAT_W-1:0]      iss_lat,
  output logic                  stall,
  output logic                  pc_write,
  output logic [ADDR_W:0]       pend_cnt,
  output logic                  err_lost
);

  localparam int NREGS = 1 << ADDR_W;

  logic [DATA_W-1:0] regFile  [NREGS];
  logic [LAT_W-1:0]  cnt      [NREGS];
  logic [LAT_W-1:0]  cntNext  [NREGS];
  logic [ADDR_W-1:0] portAddr [NRD];
  logic [ADDR_W:0]   pendNext;
  logic              lostNext;
  logic              issAccept;
  logic [LAT_W-1:0]  issLatEff;

  always_comb begin
    for (int i = 0; i < NRD; i++) begin
      portAddr[i] = rd_addr[i*ADDR_W +: ADDR_W];
    end
  end

  // Combinational read. A same-cycle writeback to the read address is
  // forwarded, so a consumer never waits one extra cycle for the array update.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NRD; i++) begin
      if (portAddr[i] == '0) begin
        rd_data[i*DATA_W +: DATA_W] = '0;
      end else if (wr_en && wr_addr == portAddr[i]) begin
        rd_data[i*DATA_W +: DATA_W] = wr_data;
      end else begin
        rd_data[i*DATA_W +: DATA_W] = regFile[portAddr[i]];
      end
    end
  end

  // Hazard: an enabled port reads a pending register that is not being
  // written back in this same cycle. The bypass resolves that last case.
  always_comb begin
    stall = 1'b0;
    for (int i = 0; i < NRD; i++) begin
      if (rd_en[i] && portAddr[i] != '0 && cnt[portAddr[i]] != '0 &&
          !(wr_en && wr_addr == portAddr[i])) begin
        stall = 1'b1;
      end
    end
  end

  assign pc_write  = ~stall;
  assign issAccept = iss_valid && !stall && iss_dst != '0;
  // A latency of zero would never mark the register pending, so it is promoted to one.
  assign issLatEff = (iss_lat == '0) ? LAT_W'(1) : iss_lat;

  // Per-register counter update with priority issue > writeback > decrement.
  // pend_cnt is tracked by the edges of each register's pending bit rather
  // than by a full recount. r0 is never pending, so the count stays below NREGS.
  always_comb begin
    pendNext   = pend_cnt;
    lostNext   = 1'b0;
    cntNext[0] = '0;
    for (int r = 1; r < NREGS; r++) begin
      cntNext[r] = cnt[r];
      if (issAccept && iss_dst == ADDR_W'(r)) begin
        cntNext[r] = issLatEff;
      end else if (wr_en && wr_addr == ADDR_W'(r)) begin
        cntNext[r] = '0;
      end else if (cnt[r] != '0) begin
        cntNext[r] = cnt[r] - LAT_W'(1);
      end

      if (cnt[r] == LAT_W'(1) && !(issAccept && iss_dst == ADDR_W'(r)) &&
          !(wr_en && wr_addr == ADDR_W'(r))) begin
        lostNext = 1'b1;
      end

      if (cnt[r] == '0 && cntNext[r] != '0) begin
        pendNext = pendNext + (ADDR_W+1)'(1);
      end else if (cnt[r] != '0 && cntNext[r] == '0) begin
        pendNext = pendNext - (ADDR_W+1)'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++) begin
        regFile[r] <= '0;
        cnt[r]     <= '0;
      end
      pend_cnt <= '0;
      err_lost <= 1'b0;
    end else begin
      if (wr_en && wr_addr != '0) begin
        regFile[wr_addr] <= wr_data;
      end
      for (int r = 0; r < NREGS; r++) begin
        cnt[r] <= cntNext[r];
      end
      pend_cnt <= pendNext;
      if (lostNext) begin
        err_lost <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_id_regfile_sb.sv
// Directed bench for id_regfile_sb. Expected values are pushed to exp_q as
// each step is driven and popped in order when the DUT output is sampled.

module tb_id_regfile_sb;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NRD    = 2;
  localparam int LAT_W  = 3;
  localparam int CW     = 64;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NRD-1:0]        rd_en;
  logic [NRD*ADDR_W-1:0] rd_addr;
  logic [NRD*DATA_W-1:0] rd_data;
  logic                  wr_en;
  logic [ADDR_W-1:0]     wr_addr;
  logic [DATA_W-1:0]     wr_data;
  logic                  iss_valid;
  logic [ADDR_W-1:0]     iss_dst;
  logic [LAT_W-1:0]      iss_lat;
  logic                  stall;
  logic                  pc_write;
  logic [ADDR_W:0]       pend_cnt;
  logic                  err_lost;

  int checks   = 0;
  int failures = 0;
  logic [CW-1:0] exp_q[$];

  id_regfile_sb #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NRD(NRD), .LAT_W(LAT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_valid(iss_valid), .iss_dst(iss_dst), .iss_lat(iss_lat),
    .stall(stall), .pc_write(pc_write), .pend_cnt(pend_cnt), .err_lost(err_lost)
  );

  // clock
  always #5 clk = ~clk;

  // scoreboard
  task automatic push_exp(input logic [CW-1:0] v);
    exp_q.push_back(v);
  endtask

  task automatic compare(input string tag, input logic [CW-1:0] obs);
    logic [CW-1:0] exp_v;
    if (exp_q.size() == 0) exp_v = 'x;
    else exp_v = exp_q.pop_front();
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  // drivers
  task automatic idle();
    rd_en     = '0;
    rd_addr   = '0;
    wr_en     = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    iss_valid = 1'b0;
    iss_dst   = '0;
    iss_lat   = '0;
  endtask

  task automatic set_rd(input int p, input logic en, input logic [ADDR_W-1:0] a);
    rd_en[p] = en;
    rd_addr[p*ADDR_W +: ADDR_W] = a;
  endtask

  task automatic wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    wr_en = 1'b1;
    wr_addr = a;
    wr_data = d;
  endtask

  task automatic iss(input logic [ADDR_W-1:0] dst, input logic [LAT_W-1:0] lat);
    iss_valid = 1'b1;
    iss_dst = dst;
    iss_lat = lat;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset state
    idle();
    rst_n = 1'b0;
    set_rd(0, 1'b1, 5'd5);
    set_rd(1, 1'b1, 5'd8);
    #12;
    push_exp(0); push_exp(0); push_exp(0); push_exp(1); push_exp(0); push_exp(0);
    compare("reset_rd0", rd_data[DATA_W-1:0]);
    compare("reset_rd1", rd_data[2*DATA_W-1:DATA_W]);
    compare("reset_stall", stall);
    compare("reset_pc_write", pc_write);
    compare("reset_pend_cnt", pend_cnt);
    compare("reset_err_lost", err_lost);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // write r5, bypass then registered read
    idle(); wr(5'd5, 32'h12345678); set_rd(0, 1'b1, 5'd5);
    push_exp(64'h12345678); #1;
    compare("r5_bypass", rd_data[DATA_W-1:0]);
    tick();
    idle(); set_rd(0, 1'b1, 5'd5);
    push_exp(64'h12345678); push_exp(0); #1;
    compare("r5_read", rd_data[DATA_W-1:0]);
    compare("err_after_plain_write", err_lost);
    tick();

    // r0 is hardwired
    idle(); wr(5'd0, 32'hFFFFFFFF); set_rd(0, 1'b1, 5'd0);
    push_exp(0); #1;
    compare("r0_bypass", rd_data[DATA_W-1:0]);
    tick();
    idle(); set_rd(0, 1'b1, 5'd0);
    push_exp(0); #1;
    compare("r0_read", rd_data[DATA_W-1:0]);
    iss(5'd0, 3'd3);
    tick();
    idle(); push_exp(0); #1;
    compare("pend_after_r0_issue", pend_cnt);

    // issue r8 lat 3, stall two cycles, writeback in the third
    iss(5'd8, 3'd3);
    tick();
    idle(); set_rd(0, 1'b1, 5'd8);
    push_exp(1); push_exp(0); push_exp(1); #1;
    compare("r8_stall_c1", stall);
    compare("r8_pcw_c1", pc_write);
    compare("r8_pend", pend_cnt);
    tick();
    idle(); set_rd(0, 1'b1, 5'd8);
    push_exp(1); push_exp(0); #1;
    compare("r8_stall_c2", stall);
    compare("r8_pcw_c2", pc_write);
    tick();
    idle(); set_rd(0, 1'b1, 5'd8); wr(5'd8, 32'hA5);
    push_exp(0); push_exp(1); push_exp(64'hA5); #1;
    compare("r8_stall_wb", stall);
    compare("r8_pcw_wb", pc_write);
    compare("r8_rd_wb", rd_data[DATA_W-1:0]);
    tick();
    idle(); push_exp(0); push_exp(0); #1;
    compare("r8_pend_cleared", pend_cnt);
    compare("r8_err", err_lost);

    // latency zero counts as one
    iss(5'd6, 3'd0);
    tick();
    idle(); set_rd(0, 1'b1, 5'd6);
    push_exp(1); push_exp(1); #1;
    compare("lat0_stall", stall);
    compare("lat0_pend", pend_cnt);
    wr(5'd6, 32'h66);
    push_exp(0); #1;
    compare("lat0_stall_wb", stall);
    tick();
    idle(); push_exp(0); push_exp(0); #1;
    compare("lat0_pend_cleared", pend_cnt);
    compare("lat0_err", err_lost);

    // issue during stall is dropped
    iss(5'd12, 3'd3);
    tick();
    idle(); set_rd(0, 1'b1, 5'd12); iss(5'd10, 3'd5);
    push_exp(1); #1;
    compare("r12_stall", stall);
    tick();
    idle(); set_rd(0, 1'b1, 5'd10); wr(5'd12, 32'hC);
    push_exp(1); push_exp(0); #1;
    compare("pend_after_stalled_issue", pend_cnt);
    compare("r10_not_pending", stall);
    tick();
    idle(); push_exp(0); #1;
    compare("r12_pend_cleared", pend_cnt);

    // same-cycle issue and write: issue wins and reloads the counter
    iss(5'd11, 3'd2);
    tick();
    idle(); iss(5'd11, 3'd5); wr(5'd11, 32'hB11);
    tick();
    idle(); set_rd(0, 1'b1, 5'd11);
    push_exp(1); push_exp(1); push_exp(64'hB11); #1;
    compare("r11_pend", pend_cnt);
    compare("r11_stall", stall);
    compare("r11_data", rd_data[DATA_W-1:0]);
    for (int k = 0; k < 4; k++) begin
      tick();
      idle(); set_rd(0, 1'b1, 5'd11);
      push_exp(1); #1;
      compare("r11_stall_hold", stall);
    end
    wr(5'd11, 32'hB12);
    push_exp(0); #1;
    compare("r11_stall_wb", stall);
    tick();
    idle(); push_exp(0); push_exp(0); #1;
    compare("r11_pend_cleared", pend_cnt);
    compare("r11_err", err_lost);

    // pend_cnt across re-issue, and port enables
    iss(5'd3, 3'd7);
    tick();
    idle(); push_exp(1); #1;
    compare("pend_r3", pend_cnt);
    iss(5'd4, 3'd7);
    tick();
    idle(); push_exp(2); #1;
    compare("pend_r3_r4", pend_cnt);
    iss(5'd3, 3'd7);
    tick();
    idle(); push_exp(2); #1;
    compare("pend_reissue_r3", pend_cnt);
    set_rd(0, 1'b0, 5'd3); set_rd(1, 1'b1, 5'd4);
    push_exp(1); #1;
    compare("stall_port1_r4", stall);
    tick();
    idle(); set_rd(0, 1'b0, 5'd3); set_rd(1, 1'b0, 5'd4);
    push_exp(0); #1;
    compare("stall_no_enable", stall);
    set_rd(1, 1'b1, 5'd5);
    push_exp(0); #1;
    compare("stall_port1_r5", stall);
    set_rd(0, 1'b1, 5'd3);
    push_exp(1); #1;
    compare("stall_port0_r3", stall);
    tick();
    idle(); wr(5'd4, 32'h4);
    tick();
    idle(); push_exp(1); #1;
    compare("pend_after_wb_r4", pend_cnt);
    wr(5'd3, 32'h3);
    tick();
    idle(); push_exp(0); push_exp(0); #1;
    compare("pend_after_wb_r3", pend_cnt);
    compare("err_before_lost", err_lost);

    // lost writeback
    iss(5'd9, 3'd2);
    tick();
    idle(); push_exp(0); push_exp(1); #1;
    compare("r9_err_c1", err_lost);
    compare("r9_pend", pend_cnt);
    tick();
    push_exp(0); #1;
    compare("r9_err_at_cnt1", err_lost);
    tick();
    push_exp(1); push_exp(0); #1;
    compare("r9_err_set", err_lost);
    compare("r9_pend_expired", pend_cnt);
    tick();
    tick();
    push_exp(1); #1;
    compare("err_sticky", err_lost);

    // asynchronous reset mid-operation
    iss(5'd20, 3'd7);
    tick();
    idle(); set_rd(0, 1'b1, 5'd20); set_rd(1, 1'b1, 5'd5);
    push_exp(1); #1;
    compare("r20_stall", stall);
    #2;
    rst_n = 1'b0;
    #1;
    push_exp(0); push_exp(0); push_exp(0); push_exp(1); push_exp(0);
    compare("async_rst_err", err_lost);
    compare("async_rst_pend", pend_cnt);
    compare("async_rst_stall", stall);
    compare("async_rst_pcw", pc_write);
    compare("async_rst_rd1", rd_data[2*DATA_W-1:DATA_W]);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    idle(); set_rd(0, 1'b1, 5'd20); set_rd(1, 1'b1, 5'd5);
    push_exp(0); push_exp(0); push_exp(0); #1;
    compare("post_rst_stall", stall);
    compare("post_rst_rd1", rd_data[2*DATA_W-1:DATA_W]);
    compare("post_rst_err", err_lost);

    checks++;
    assert (exp_q.size() == 0) else begin
      failures++;
      $error("FAIL queue_empty observed=%0d expected=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
